// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - SR latch initiator: exclusive S/R pulse, dead time, Q/Qn readback confirm (option: SR_SYNC_EN)
module sr_latch_driver #(
    parameter int PULSE_CYCLES   = 2,
    parameter int DEAD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CNT_W          = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_in,
    input  logic qn_in,
    output logic done,
    output logic err,
    output logic state_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2,
        CHECK = 2'd3
    } state_e;

    // Zero-valued pulse and timeout lengths degrade to a single cycle.
    localparam int P_EFF = (PULSE_CYCLES   < 1) ? 1 : PULSE_CYCLES;
    localparam int T_EFF = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int D_EFF = (DEAD_CYCLES    < 1) ? 1 : DEAD_CYCLES;
    localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

    localparam logic [CNT_W-1:0] P_LOAD  = CNT_W'(P_EFF - 1);
    localparam logic [CNT_W-1:0] D_LOAD  = CNT_W'(D_EFF - 1);
    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(T_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_e           fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             lstate_q, lstate_d;
    logic             q_rb, qn_rb;
    logic             match;

`ifdef SR_SYNC_EN
    logic [1:0] q_sync_q;
    logic [1:0] qn_sync_q;

    // Two-flop synchronizers so an asynchronous latch can be read back safely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync_q  <= 2'b00;
            qn_sync_q <= 2'b00;
        end else begin
            q_sync_q  <= {q_sync_q[0], q_in};
            qn_sync_q <= {qn_sync_q[0], qn_in};
        end
    end

    assign q_rb  = q_sync_q[1];
    assign qn_rb = qn_sync_q[1];
`else
    assign q_rb  = q_in;
    assign qn_rb = qn_in;
`endif

    // Q==Qn (invalid or unsettled latch) can never satisfy both terms.
    assign match = (q_rb == op_q) && (qn_rb == !op_q);

    assign req_ready = (fsm_q == IDLE);
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_q   = lstate_q;

    // State, counter and registered latch drives; reset clears S/R without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            lstate_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            err_q    <= err_d;
            lstate_q <= lstate_d;
        end
    end

    // Next-state logic; S and R next values are only ever set as complements in PULSE.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        s_d      = 1'b0;
        r_d      = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        lstate_d = lstate_q;
        case (fsm_q)
            IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    s_d   = req_op;
                    r_d   = !req_op;
                    cnt_d = P_LOAD;
                    fsm_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_ZERO) begin
                    if (HAS_DEAD) begin
                        cnt_d = D_LOAD;
                        fsm_d = DEAD;
                    end else begin
                        cnt_d = '0;
                        fsm_d = CHECK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    s_d   = op_q;
                    r_d   = !op_q;
                end
            end
            DEAD: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d = '0;
                    fsm_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CHECK: begin
                if (match) begin
                    done_d   = 1'b1;
                    lstate_d = op_q;
                    cnt_d    = '0;
                    fsm_d    = IDLE;
                end else if (cnt_q == T_LAST) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                    fsm_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - directed self-checking bench for sr_latch_driver
module tb_sr_latch_driver;

`ifdef SR_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_op = 1'b0;
    logic req_ready;
    logic s, r;
    logic q_in, qn_in;
    logic done, err, state_q;

    int n_checks = 0;
    int n_pass = 0;

    // 0 = ideal latch, 1 = stuck at Q=0, 2 = invalid Q=Qn=1
    int   mode = 0;
    logic latch_q = 1'b0;
    logic bad_pulse;

    sr_latch_driver dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_op(req_op),
        .req_ready(req_ready),
        .s(s),
        .r(r),
        .q_in(q_in),
        .qn_in(qn_in),
        .done(done),
        .err(err),
        .state_q(state_q)
    );

    always #5 clk = ~clk;

    // Ideal NOR latch: reacts to S/R in zero time.
    always @(s or r) begin
        if (s) latch_q = 1'b1;
        else if (r) latch_q = 1'b0;
    end

    assign q_in  = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : latch_q;
    assign qn_in = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b1 : !latch_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled mid-cycle across the whole run.
    always @(negedge clk) begin
        check("s_and_r", {31'b0, s & r}, 32'd0);
        check("done_and_err", {31'b0, done & err}, 32'd0);
        check("drive_when_ready", {31'b0, req_ready & (s | r)}, 32'd0);
    end

    initial begin
        #12;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_sr", {30'b0, s, r}, 32'd0);
        check("rst_done_err", {30'b0, done, err}, 32'd0);
        check("rst_state", {31'b0, state_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Set command, ideal latch
        req_valid = 1'b1; req_op = 1'b1;
        tick();                               // E0
        req_valid = 1'b0;
        check("set_e0_sr", {30'b0, s, r}, 32'h2);
        check("set_e0_ready", {31'b0, req_ready}, 32'd0);
        tick();                               // E1
        check("set_e1_sr", {30'b0, s, r}, 32'h2);
        tick();                               // E2
        check("set_dead_sr", {30'b0, s, r}, 32'h0);
        tick();                               // E3
        check("set_e3_done", {31'b0, done}, 32'd0);
        tick();                               // E4
        check("set_done", {31'b0, done}, 32'd1);
        check("set_err", {31'b0, err}, 32'd0);
        check("set_state", {31'b0, state_q}, 32'd1);
        check("set_ready", {31'b0, req_ready}, 32'd1);
        tick();
        check("set_done_1cyc", {31'b0, done}, 32'd0);

        // Reset command
        req_valid = 1'b1; req_op = 1'b0;
        tick();
        req_valid = 1'b0;
        check("rst_e0_sr", {30'b0, s, r}, 32'h1);
        tick();
        check("rst_e1_sr", {30'b0, s, r}, 32'h1);
        tick();
        check("rst_dead_sr", {30'b0, s, r}, 32'h0);
        tick();
        tick();
        check("rst_done", {31'b0, done}, 32'd1);
        check("rst_state", {31'b0, state_q}, 32'd0);
        tick();

        // Stuck latch: eight failing compares then err
        mode = 1;
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("stuck_wait", {30'b0, done, err}, 32'd0);
        end
        tick();
        check("stuck_err", {31'b0, err}, 32'd1);
        check("stuck_done", {31'b0, done}, 32'd0);
        check("stuck_state", {31'b0, state_q}, 32'd0);
        check("stuck_ready", {31'b0, req_ready}, 32'd1);
        tick();
        check("stuck_err_1cyc", {31'b0, err}, 32'd0);

        // Invalid readback for three compares, then a good latch
        mode = 2;
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("inv_wait", {30'b0, done, err}, 32'd0);
        end
        mode = 0;
        for (int i = 0; i < LAG; i++) begin
            tick();
            check("inv_lag", {30'b0, done, err}, 32'd0);
        end
        tick();
        check("inv_done", {31'b0, done}, 32'd1);
        check("inv_err", {31'b0, err}, 32'd0);
        check("inv_state", {31'b0, state_q}, 32'd1);
        tick();

        // Busy rejection: valid held with toggling op
        req_valid = 1'b1; req_op = 1'b0;
        tick();                               // E0 accepts reset
        for (int i = 0; i < 3; i++) begin
            req_op = ~req_op;
            check("busy_ready", {31'b0, req_ready}, 32'd0);
            if (i < 2) check("busy_pulse_sr", {30'b0, s, r}, 32'h1);
            tick();
        end
        req_op = 1'b1;
        check("busy_check_ready", {31'b0, req_ready}, 32'd0);
        tick();                               // E4
        check("busy_done", {31'b0, done}, 32'd1);
        check("busy_state0", {31'b0, state_q}, 32'd0);
        tick();                               // E5 accepts set
        req_valid = 1'b0;
        check("busy_second_sr", {30'b0, s, r}, 32'h2);
        for (int i = 0; i < 3; i++) tick();
        tick();
        check("busy_second_done", {31'b0, done}, 32'd1);
        check("busy_state1", {31'b0, state_q}, 32'd1);
        tick();

        // Async reset in the middle of a pulse
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        req_valid = 1'b0;
        check("ar_pulse_s", {31'b0, s}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_s_dropped", {30'b0, s, r}, 32'h0);
        check("ar_state", {31'b0, state_q}, 32'd0);
        check("ar_ready", {31'b0, req_ready}, 32'd1);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        bad_pulse = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || err || s || r) bad_pulse = 1'b1;
        end
        check("ar_quiet", {31'b0, bad_pulse}, 32'd0);
        check("ar_state_after", {31'b0, state_q}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
